// File: rtl/loop_index_sequencer.sv
// Round-robin loop sequencer: grants one requester and walks a shared index from its start value to LIMIT-1.
// Latency: grant to done_o is LIMIT-start+1 cycles; one IDLE cycle always separates runs.
// Backpressure: none; requesters hold req_i until done_o, abort_i cuts a run short with done_ok_o low.
// Optional: define LOOP_INDEX_SEQUENCER_ITER_COUNT_EN to add the iter_count_o iteration counter.
module loop_index_sequencer #(
  parameter int IDX_W   = 4,
  parameter int LIMIT   = 10,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*IDX_W-1:0] start_idx_i,
  input  logic                     abort_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [IDX_W-1:0]         index_o,
  output logic                     loop_active_o,
  output logic                     done_o,
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
  output logic [IDX_W:0]           iter_count_o,
`endif
  output logic                     done_ok_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // cnt is one bit wider than the index so LIMIT = 2**IDX_W does not wrap
  localparam logic [IDX_W:0] LIM  = (IDX_W+1)'(LIMIT);
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(LIMIT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               ok_q, ok_d;
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
  logic [IDX_W:0]     iter_q, iter_d;
`endif

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_start;

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping
  always_comb begin
    int pos;
    pos     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    // Scan offsets high to low so the smallest offset from rr_ptr is the last (winning) assignment
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_i[pos]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(pos);
      end
    end
  end

  assign win_start = start_idx_i[int'(win_idx)*IDX_W +: IDX_W];

  // Next-state logic for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ok_d     = ok_q;
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    iter_d   = iter_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          win_d   = win_idx;
          cnt_d   = {1'b0, win_start};
          // Zero-iteration runs report the start value in DONE
          last_d  = win_start;
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
          iter_d  = '0;
`endif
          if ({1'b0, win_start} < LIM) begin
            state_d = ST_RUN;
            ok_d    = 1'b0;
          end else begin
            state_d = ST_DONE;
            ok_d    = ({1'b0, win_start} == LIM);
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          // Abort beats the last iteration: no increment, completion flagged not-ok
          state_d = ST_DONE;
          ok_d    = 1'b0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          last_d = cnt_q[IDX_W-1:0];
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
          iter_d = iter_q + 1'b1;
`endif
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            ok_d    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        ok_d     = 1'b0;
        rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ok_d    = 1'b0;
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      ok_q     <= 1'b0;
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
      iter_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ok_q     <= ok_d;
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
      iter_q   <= iter_d;
`endif
    end
  end

  // Outputs decoded from state; IDLE shows all-zero
  always_comb begin
    grant_o       = grant_q;
    loop_active_o = (state_q == ST_RUN) && !abort_i;
    done_o        = (state_q == ST_DONE);
    done_ok_o     = (state_q == ST_DONE) && ok_q;
    case (state_q)
      ST_RUN:  index_o = cnt_q[IDX_W-1:0];
      ST_DONE: index_o = last_q;
      default: index_o = '0;
    endcase
  end

`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
  assign iter_count_o = iter_q;
`endif

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Directed bench for loop_index_sequencer: default instance (LIMIT=10) plus a LIMIT=16 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_loop_index_sequencer;

  logic       clk;
  logic       rst_n;

  logic [1:0] req;
  logic [7:0] start;
  logic       abort;
  logic [1:0] grant;
  logic [3:0] index;
  logic       active;
  logic       done;
  logic       done_ok;
  logic [4:0] iter_count;

  logic [1:0] req2;
  logic [7:0] start2;
  logic       abort2;
  logic [1:0] grant2;
  logic [3:0] index2;
  logic       active2;
  logic       done2;
  logic       done_ok2;
  logic [4:0] iter_count2;

  int checks;
  int failures;

  loop_index_sequencer #(.IDX_W(4), .LIMIT(10), .NUM_REQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .start_idx_i  (start),
    .abort_i      (abort),
    .grant_o      (grant),
    .index_o      (index),
    .loop_active_o(active),
    .done_o       (done),
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    .iter_count_o (iter_count),
`endif
    .done_ok_o    (done_ok)
  );

  loop_index_sequencer #(.IDX_W(4), .LIMIT(16), .NUM_REQ(2)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req2),
    .start_idx_i  (start2),
    .abort_i      (abort2),
    .grant_o      (grant2),
    .index_o      (index2),
    .loop_active_o(active2),
    .done_o       (done2),
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    .iter_count_o (iter_count2),
`endif
    .done_ok_o    (done_ok2)
  );

`ifndef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
  assign iter_count  = '0;
  assign iter_count2 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checks the full output set of the default instance in one call
  task automatic check_outs(input string tag, input int g, input int idx, input int act,
                            input int dn, input int ok);
    check_eq({tag, "_grant"},  int'(grant),   g);
    check_eq({tag, "_index"},  int'(index),   idx);
    check_eq({tag, "_active"}, int'(active),  act);
    check_eq({tag, "_done"},   int'(done),    dn);
    check_eq({tag, "_ok"},     int'(done_ok), ok);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    start    = '0;
    abort    = 1'b0;
    req2     = '0;
    start2   = '0;
    abort2   = 1'b0;

    do_reset();
    step();
    check_outs("rst", 0, 0, 0, 0, 0);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("rst_iter", int'(iter_count), 0);
`endif

    // Requester 0 from start 7: indices 7,8,9 then ok completion
    req = 2'b01; start = {4'd0, 4'd7};
    step(); check_outs("t1_c1", 1, 7, 1, 0, 0);
    step(); check_outs("t1_c2", 1, 8, 1, 0, 0);
    step(); check_outs("t1_c3", 1, 9, 1, 0, 0);
    step(); check_outs("t1_done", 1, 9, 0, 1, 1);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t1_iter", int'(iter_count), 3);
`endif
    req = 2'b00;
    step(); check_outs("t1_idle", 0, 0, 0, 0, 0);

    // Both requesting from a fresh pointer: 0, gap, 1, gap, 0
    do_reset();
    req = 2'b11; start = {4'd9, 4'd8};
    step(); check_outs("t2_r0a", 1, 8, 1, 0, 0);
    step(); check_outs("t2_r0b", 1, 9, 1, 0, 0);
    step(); check_outs("t2_r0d", 1, 9, 0, 1, 1);
    step(); check_outs("t2_gap1", 0, 0, 0, 0, 0);
    step(); check_outs("t2_r1a", 2, 9, 1, 0, 0);
    step(); check_outs("t2_r1d", 2, 9, 0, 1, 1);
    step(); check_outs("t2_gap2", 0, 0, 0, 0, 0);
    step(); check_outs("t2_r0c", 1, 8, 1, 0, 0);
    req = 2'b00;  // dropping the request mid-run must not stop it
    step(); check_outs("t2_r0e", 1, 9, 1, 0, 0);
    step(); check_outs("t2_r0f", 1, 9, 0, 1, 1);
    step(); check_outs("t2_idle", 0, 0, 0, 0, 0);

    // Start == LIMIT: straight to DONE, ok
    req = 2'b01; start = {4'd0, 4'd10};
    step(); check_outs("t3_eq", 1, 10, 0, 1, 1);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t3_iter", int'(iter_count), 0);
`endif
    req = 2'b00;
    step(); check_outs("t3_idle", 0, 0, 0, 0, 0);
    // Start beyond LIMIT: same timing, not ok
    req = 2'b01; start = {4'd0, 4'd12};
    step(); check_outs("t3_gt", 1, 12, 0, 1, 0);
    req = 2'b00;
    step(); check_outs("t3_idle2", 0, 0, 0, 0, 0);

    // Abort during the fourth RUN cycle from start 0
    req = 2'b01; start = {4'd0, 4'd0};
    step(); check_outs("t4_c1", 1, 0, 1, 0, 0);
    step(); check_outs("t4_c2", 1, 1, 1, 0, 0);
    step(); check_outs("t4_c3", 1, 2, 1, 0, 0);
    step();
    abort = 1'b1;
    #1;
    check_eq("t4_abort_active", int'(active), 0);
    check_eq("t4_abort_done", int'(done), 0);
    step(); check_outs("t4_done", 1, 2, 0, 1, 0);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t4_iter", int'(iter_count), 3);
`endif
    abort = 1'b0; req = 2'b00;
    step(); check_outs("t4_idle", 0, 0, 0, 0, 0);

    // Reset while running at index 5
    req = 2'b01; start = {4'd0, 4'd0};
    for (int i = 0; i < 6; i++) step();
    check_outs("t5_pre", 1, 5, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check_outs("t5_rst", 0, 0, 0, 0, 0);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t5_rst_iter", int'(iter_count), 0);
`endif
    step(); check_outs("t5_rst2", 0, 0, 0, 0, 0);
    rst_n = 1'b1; start = {4'd0, 4'd9};
    step(); check_outs("t5_c1", 1, 9, 1, 0, 0);
    step(); check_outs("t5_done", 1, 9, 0, 1, 1);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t5_iter", int'(iter_count), 1);
`endif
    req = 2'b00;

    // LIMIT = 2**IDX_W: 14,15 then ok with no wrap
    req2 = 2'b01; start2 = {4'd0, 4'd14};
    step();
    check_eq("t6_idx14", int'(index2), 14);
    check_eq("t6_act1", int'(active2), 1);
    step();
    check_eq("t6_idx15", int'(index2), 15);
    check_eq("t6_act2", int'(active2), 1);
    step();
    check_eq("t6_done", int'(done2), 1);
    check_eq("t6_ok", int'(done_ok2), 1);
    check_eq("t6_idx_hold", int'(index2), 15);
    check_eq("t6_grant", int'(grant2), 1);
`ifdef LOOP_INDEX_SEQUENCER_ITER_COUNT_EN
    check_eq("t6_iter", int'(iter_count2), 2);
`endif
    req2 = 2'b00;
    step();
    check_eq("t6_idle_done", int'(done2), 0);
    check_eq("t6_idle_act", int'(active2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
